// File: rtl/subword_store_if.sv
// Bundles the store request/response handshake and the word-memory bus of
// subword_store_unit into one interface.
interface subword_store_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        store_size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;

    // The store unit itself.
    modport slave (
        input  start, store_size, addr, wdata, mem_rdata,
        output busy, done, misalign, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    // Pipeline control plus data memory, seen from outside the unit.
    modport master (
        output start, store_size, addr, wdata, mem_rdata,
        input  busy, done, misalign, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/subword_store_unit.sv
// Byte/half/word store into a word-only memory via read-modify-write.
// Define STORE_ALIGN_CHECK_EN to fault misaligned half/word stores instead of forcing alignment.
module subword_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    subword_store_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       wdata_reg;
    logic [1:0]        size_reg;
    logic [31:0]       wbuf_reg;
    logic [31:0]       merged;
    logic              accept;
    logic              req_word;
    logic              req_misaligned;

    assign accept   = (state_reg == IDLE) && bus.start;
    // Reserved size 2'b11 shares the word path.
    assign req_word = bus.store_size[1];

`ifdef STORE_ALIGN_CHECK_EN
    logic misalign_reg;

    assign req_misaligned = req_word ? (bus.addr[1:0] != 2'b00)
                                     : (bus.store_size[0] && bus.addr[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else if (accept) begin
            misalign_reg <= req_misaligned;
        end
    end

    assign bus.misalign = (state_reg == DONE) && misalign_reg;
`else
    assign req_misaligned = 1'b0;
    assign bus.misalign   = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (req_misaligned) begin
                        state_next = DONE;
                    end else if (req_word) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = MERGE;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-lane merge: a selected lane takes the truncated register value,
    // every other lane is passed through exactly as read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_sel;
            logic [7:0] lane_src;

            assign lane_sel = size_reg[1] ||
                              (size_reg[0] ? (addr_reg[1] == LANE[1])
                                           : (addr_reg[1:0] == LANE));
            assign lane_src = size_reg[0] ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[7:0];
            assign merged[8*gi +: 8] = lane_sel ? lane_src : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= '0;
            wbuf_reg  <= '0;
        end else if (accept) begin
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata[15:0];
            size_reg  <= bus.store_size;
            // The word path skips MERGE, so its write word is loaded here.
            wbuf_reg  <= bus.wdata;
        end else if (state_reg == MERGE) begin
            wbuf_reg  <= merged;
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.mem_rd_en = (state_reg == READ);
    assign bus.mem_wr_en = (state_reg == WRITE);
    assign bus.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = wbuf_reg;
endmodule

// File: tb/tb_subword_store_unit.sv
// Directed bench for subword_store_unit with a small word-memory model.
module tb_subword_store_unit;
    logic clk;
    logic reset;

    subword_store_if #(.ADDR_W(32)) bus ();

    subword_store_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic        load_req;
    logic [31:0] load_val;
    int          rd_cnt;
    int          wr_cnt;
    int          done_cnt;
    int          checks;
    int          errors;

    always @(posedge clk) begin
        if (load_req) begin
            mem[64] <= load_val;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (bus.done)      done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] v);
        load_req = 1'b1;
        load_val = v;
        tick();
        load_req = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.start      = 1'b1;
        bus.store_size = sz;
        bus.addr       = a;
        bus.wdata      = d;
        tick();
        bus.start = 1'b0;
    endtask

    int rd0;
    int wr0;
    int dn0;

    initial begin
        checks = 0;
        errors = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        load_req = 1'b0;
        load_val = '0;
        bus.start = 1'b0;
        bus.store_size = 2'b00;
        bus.addr = '0;
        bus.wdata = '0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_wr", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        reset = 1'b0;

        // Byte store, full cycle-by-cycle timing.
        preload(32'hAABBCCDD);
        rd0 = rd_cnt;
        issue(2'b00, 32'h102, 32'h12345678);
        $display("txn byte addr=0x102 wdata=0x12345678");
        chk("sb_c1_rd", 32'(bus.mem_rd_en), 32'd1);
        chk("sb_c1_wr", 32'(bus.mem_wr_en), 32'd0);
        chk("sb_c1_addr", bus.mem_addr, 32'h100);
        tick();
        chk("sb_c2_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("sb_c2_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("sb_c3_wr", 32'(bus.mem_wr_en), 32'd1);
        chk("sb_c3_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("sb_c3_addr", bus.mem_addr, 32'h100);
        chk("sb_c3_wdata", bus.mem_wdata, 32'hAA78CCDD);
        tick();
        chk("sb_c4_done", 32'(bus.done), 32'd1);
        chk("sb_c4_wr", 32'(bus.mem_wr_en), 32'd0);
        tick();
        chk("sb_c5_busy", 32'(bus.busy), 32'd0);
        chk("sb_c5_done", 32'(bus.done), 32'd0);
        chk("sb_mem", mem[64], 32'hAA78CCDD);
        chk("sb_rdcnt", 32'(rd_cnt - rd0), 32'd1);

        // Half store, upper lane.
        preload(32'hAABBCCDD);
        issue(2'b01, 32'h102, 32'hFFFF8001);
        $display("txn half addr=0x102 wdata=0xFFFF8001");
        tick();
        tick();
        chk("sh_hi_wr", 32'(bus.mem_wr_en), 32'd1);
        chk("sh_hi_wdata", bus.mem_wdata, 32'h8001CCDD);
        tick();
        chk("sh_hi_done", 32'(bus.done), 32'd1);
        tick();

        // Half store, lower lane.
        preload(32'hAABBCCDD);
        issue(2'b01, 32'h100, 32'hFFFF8001);
        $display("txn half addr=0x100 wdata=0xFFFF8001");
        tick();
        tick();
        chk("sh_lo_wr", 32'(bus.mem_wr_en), 32'd1);
        chk("sh_lo_wdata", bus.mem_wdata, 32'hAABB8001);
        tick();
        tick();
        chk("sh_lo_mem", mem[64], 32'hAABB8001);

        // Word store: no read, write at cycle 1, done at cycle 2.
        rd0 = rd_cnt;
        issue(2'b10, 32'h104, 32'hDEADBEEF);
        $display("txn word addr=0x104 wdata=0xDEADBEEF");
        chk("sw_c1_wr", 32'(bus.mem_wr_en), 32'd1);
        chk("sw_c1_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("sw_c1_addr", bus.mem_addr, 32'h104);
        chk("sw_c1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        chk("sw_c2_done", 32'(bus.done), 32'd1);
        tick();
        chk("sw_c3_busy", 32'(bus.busy), 32'd0);
        chk("sw_rdcnt", 32'(rd_cnt - rd0), 32'd0);
        chk("sw_mem", mem[65], 32'hDEADBEEF);

        // Start held high during cycles 1-3 of a byte store is ignored.
        preload(32'hAABBCCDD);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue(2'b00, 32'h101, 32'h00000055);
        $display("txn byte addr=0x101 wdata=0x55 with start held while busy");
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        chk("ign_done", 32'(bus.done), 32'd1);
        tick();
        chk("ign_busy", 32'(bus.busy), 32'd0);
        repeat (5) tick();
        chk("ign_wrcnt", 32'(wr_cnt - wr0), 32'd1);
        chk("ign_donecnt", 32'(done_cnt - dn0), 32'd1);
        chk("ign_mem", mem[64], 32'hAABB55DD);

        // Asynchronous reset in the middle of MERGE.
        preload(32'hAABBCCDD);
        wr0 = wr_cnt;
        issue(2'b00, 32'h100, 32'h000000EE);
        $display("txn byte addr=0x100 wdata=0xEE aborted by reset in MERGE");
        tick();
        chk("ar_merge_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_wr", 32'(bus.mem_wr_en), 32'd0);
        chk("ar_rd", 32'(bus.mem_rd_en), 32'd0);
        chk("ar_addr", bus.mem_addr, 32'h0);
        chk("ar_wdata", bus.mem_wdata, 32'h0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();
        chk("ar_wrcnt", 32'(wr_cnt - wr0), 32'd0);
        chk("ar_mem", mem[64], 32'hAABBCCDD);

        // Misaligned half store.
        preload(32'hAABBCCDD);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(2'b01, 32'h101, 32'h1234ABCD);
        $display("txn half addr=0x101 wdata=0x1234ABCD (misaligned)");
`ifdef STORE_ALIGN_CHECK_EN
        chk("mis_done", 32'(bus.done), 32'd1);
        chk("mis_flag", 32'(bus.misalign), 32'd1);
        tick();
        chk("mis_busy", 32'(bus.busy), 32'd0);
        chk("mis_flag_clr", 32'(bus.misalign), 32'd0);
        chk("mis_rdcnt", 32'(rd_cnt - rd0), 32'd0);
        chk("mis_wrcnt", 32'(wr_cnt - wr0), 32'd0);
        chk("mis_mem", mem[64], 32'hAABBCCDD);
`else
        chk("mis_c1_rd", 32'(bus.mem_rd_en), 32'd1);
        tick();
        tick();
        chk("mis_c3_wr", 32'(bus.mem_wr_en), 32'd1);
        chk("mis_c3_addr", bus.mem_addr, 32'h100);
        chk("mis_c3_wdata", bus.mem_wdata, 32'hAABBABCD);
        tick();
        chk("mis_c4_done", 32'(bus.done), 32'd1);
        chk("mis_c4_flag", 32'(bus.misalign), 32'd0);
        tick();
        chk("mis_wrcnt", 32'(wr_cnt - wr0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
